icache_ctrl: RTL

//  Direct-mapped instruction cache + miss FSM between the IF stage and the memory

---
 rtl/icache_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache with a two-state miss FSM in front of unified_mem.
// Hits answer combinationally; a miss stalls IF, fetches one 4-word line and refills it.
module icache_ctrl #(
  parameter int NUM_LINES  = 32,
  parameter int MISS_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           if_addr,
  input  logic                  if_re,
  input  logic                  flush,
  output logic [15:0]           instr,
  output logic                  instr_vld,
  output logic                  stall,
  output logic                  mem_rw,
  output logic [13:0]           mem_addr,
  output logic [63:0]           mem_wdata,
  output logic                  mem_re,
  input  logic [63:0]           mem_rd_data,
  input  logic                  mem_rdy,
  output logic [MISS_CNT_W-1:0] miss_cnt
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 14 - IDX_W;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                  state_q, state_d;
  logic [NUM_LINES-1:0]    valid_q, valid_d;
  logic [13:0]             miss_addr_q, miss_addr_d;
  logic [MISS_CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]        tag_arr  [NUM_LINES];
  logic [63:0]             data_arr [NUM_LINES];

  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;
  logic [1:0]              off;
  logic [IDX_W-1:0]        miss_idx;
  logic                    hit;
  logic                    refill_we;
  logic [63:0]             line_data;

  assign off       = if_addr[1:0];
  assign idx       = if_addr[IDX_W+1:2];
  assign tag       = if_addr[15:IDX_W+2];
  assign miss_idx  = miss_addr_q[IDX_W-1:0];
  assign line_data = data_arr[idx];

  assign hit = if_re & valid_q[idx] & (tag_arr[idx] == tag) & (state_q == IDLE);

  // A flush in the same cycle as mem_rdy discards the returning line.
  assign refill_we = rst_n & (state_q == MISS) & mem_rdy & ~flush;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    miss_addr_d = miss_addr_q;
    miss_cnt_d  = miss_cnt_q;
    case (state_q)
      IDLE: begin
        if (if_re && !hit) begin
          miss_addr_d = if_addr[15:2];
          if (miss_cnt_q != {MISS_CNT_W{1'b1}}) begin
            miss_cnt_d = miss_cnt_q + MISS_CNT_W'(1);
          end
          state_d = MISS;
        end
      end
      MISS: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mem_rdy) begin
          valid_d[miss_idx] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_addr_q <= miss_addr_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Tag/data storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (refill_we) begin
      tag_arr[miss_idx]  <= miss_addr_q[13:IDX_W];
      data_arr[miss_idx] <= mem_rd_data;
    end
  end

  assign instr_vld = hit & rst_n;
  assign instr     = instr_vld ? line_data[{off, 4'b0000} +: 16] : 16'h0000;
  assign stall     = if_re & ~instr_vld;
  assign mem_re    = rst_n & (state_q == MISS);
  assign mem_addr  = mem_re ? miss_addr_q : 14'h0000;
  assign mem_rw    = 1'b0;
  assign mem_wdata = 64'h0;
  assign miss_cnt  = miss_cnt_q;

endmodule
